// File: rtl/clock_pkg.sv
// Shared constants, time record and 12 h mapping for the time-of-day counter.
package clock_pkg;

   localparam int unsigned SEC_MAX   = 59;
   localparam int unsigned MIN_MAX   = 59;
   localparam int unsigned HR_MAX    = 23;
   localparam int unsigned HR12_NOON = 12;

   typedef struct packed {
      logic [4:0] hours;
      logic [5:0] minutes;
      logic [5:0] seconds;
   } time_t;

   // 0 -> 12, 1..12 unchanged, 13..23 -> h-12
   function automatic logic [4:0] to_12h(input logic [4:0] h);
      if (h == 5'd0)
         return 5'(HR12_NOON);
      else if (h > 5'(HR12_NOON))
         return h - 5'(HR12_NOON);
      else
         return h;
   endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Seconds divider: one tick every CLK_HZ enabled cycles; holds while run=0.
module sec_prescaler #(
   parameter int unsigned CLK_HZ = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] count;

   assign tick = run & (count == LAST);

   always_ff @(posedge clk) begin
      if (!reset_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (run)
         count <= tick ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/timekeeping_gen2.sv
// 24 h time-of-day counter with prescaler, load, stepping and 12/24 h display.
// Optional alarm comparator enabled by defining TIMEKEEPING_ALARM_EN.
module timekeeping_gen2
   import clock_pkg::*;
#(
   parameter int unsigned CLK_HZ = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   input  logic             mode_12h,
   input  logic             load_time,
   input  logic [CNT_W-1:0] load_hours,
   input  logic [CNT_W-1:0] load_minutes,
   input  logic [CNT_W-1:0] load_seconds,
   input  logic             inc_hour,
   input  logic             inc_min,
   output logic [CNT_W-1:0] hours_disp,
   output logic [CNT_W-1:0] min_disp,
   output logic [CNT_W-1:0] sec_disp,
   output logic             pm,
   output logic             sec_pulse,
   output logic             day_wrap,
   output logic             load_err
`ifdef TIMEKEEPING_ALARM_EN
   ,
   input  logic             alarm_set,
   input  logic             alarm_clear,
   input  logic [CNT_W-1:0] alarm_hours,
   input  logic [CNT_W-1:0] alarm_minutes,
   output logic             alarm_ring
`endif
);

   time_t cur, nxt;
   logic  tick, load_ok, load_bad, tick_apply, wrap, alarm_bad;

   assign load_ok  = (load_hours <= CNT_W'(HR_MAX)) && (load_minutes <= CNT_W'(MIN_MAX))
                     && (load_seconds <= CNT_W'(SEC_MAX));
   assign load_bad = load_time & ~load_ok;

   // A rejected load freezes the divider for that cycle by withholding run.
   sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run & ~load_bad),
      .clr     (load_time & load_ok),
      .tick    (tick)
   );

   always_comb begin
      nxt        = cur;
      tick_apply = 1'b0;
      wrap       = 1'b0;
      if (load_time) begin
         if (load_ok) begin
            nxt.hours   = load_hours[4:0];
            nxt.minutes = load_minutes[5:0];
            nxt.seconds = load_seconds[5:0];
         end
      end else if (inc_hour || inc_min) begin
         if (inc_hour)
            nxt.hours = (cur.hours == 5'(HR_MAX)) ? '0 : cur.hours + 5'd1;
         if (inc_min)
            nxt.minutes = (cur.minutes == 6'(MIN_MAX)) ? '0 : cur.minutes + 6'd1;
      end else if (tick) begin
         tick_apply = 1'b1;
         if (cur.seconds != 6'(SEC_MAX)) begin
            nxt.seconds = cur.seconds + 6'd1;
         end else begin
            nxt.seconds = '0;
            if (cur.minutes != 6'(MIN_MAX)) begin
               nxt.minutes = cur.minutes + 6'd1;
            end else begin
               nxt.minutes = '0;
               if (cur.hours != 5'(HR_MAX)) begin
                  nxt.hours = cur.hours + 5'd1;
               end else begin
                  nxt.hours = '0;
                  wrap      = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cur       <= '0;
         sec_pulse <= 1'b0;
         day_wrap  <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         cur       <= nxt;
         sec_pulse <= tick_apply;
         day_wrap  <= wrap;
         load_err  <= load_bad | alarm_bad;
      end
   end

   assign hours_disp = CNT_W'(mode_12h ? to_12h(cur.hours) : cur.hours);
   assign min_disp   = CNT_W'(cur.minutes);
   assign sec_disp   = CNT_W'(cur.seconds);
   assign pm         = mode_12h & (cur.hours >= 5'(HR12_NOON));

`ifdef TIMEKEEPING_ALARM_EN
   logic [4:0] alm_hours;
   logic [5:0] alm_minutes;
   logic       armed, alarm_ok, hit;

   assign alarm_ok  = (alarm_hours <= CNT_W'(HR_MAX)) && (alarm_minutes <= CNT_W'(MIN_MAX));
   assign alarm_bad = alarm_set & ~alarm_ok;
   // Only a counting tick can trigger; loads and steps never ring.
   assign hit = tick_apply & armed & (nxt.hours == alm_hours)
                & (nxt.minutes == alm_minutes) & (nxt.seconds == '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         alm_hours   <= '0;
         alm_minutes <= '0;
         armed       <= 1'b0;
         alarm_ring  <= 1'b0;
      end else if (alarm_clear) begin
         armed      <= 1'b0;
         alarm_ring <= 1'b0;
      end else begin
         if (alarm_set && alarm_ok) begin
            alm_hours   <= alarm_hours[4:0];
            alm_minutes <= alarm_minutes[5:0];
            armed       <= 1'b1;
         end
         if (hit)
            alarm_ring <= 1'b1;
      end
   end
`else
   assign alarm_bad = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeping_gen2.sv
// Randomised and directed bench for timekeeping_gen2 against a seconds-of-day model.
module tb_timekeeping_gen2;

   localparam int unsigned HZ = 4;
   localparam int unsigned W  = 8;

   typedef logic [3*W+4:0] vec_t;

   logic         clk = 1'b0;
   logic         reset_n, run, mode_12h, load_time, inc_hour, inc_min;
   logic [W-1:0] load_hours, load_minutes, load_seconds;
   logic [W-1:0] hours_disp, min_disp, sec_disp;
   logic         pm, sec_pulse, day_wrap, load_err;
`ifdef TIMEKEEPING_ALARM_EN
   logic         alarm_set, alarm_clear, alarm_ring;
   logic [W-1:0] alarm_hours, alarm_minutes;
`endif

   int checks = 0;
   int errors = 0;

   // model state: time as seconds of day, prescaler phase, registered flags
   int m_t, m_ph, a_t;
   bit m_sp, m_dw, m_le, a_arm, a_ring;

   always #5 clk = ~clk;

   timekeeping_gen2 #(.CLK_HZ(HZ), .CNT_W(W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .run          (run),
      .mode_12h     (mode_12h),
      .load_time    (load_time),
      .load_hours   (load_hours),
      .load_minutes (load_minutes),
      .load_seconds (load_seconds),
      .inc_hour     (inc_hour),
      .inc_min      (inc_min),
      .hours_disp   (hours_disp),
      .min_disp     (min_disp),
      .sec_disp     (sec_disp),
      .pm           (pm),
      .sec_pulse    (sec_pulse),
      .day_wrap     (day_wrap),
      .load_err     (load_err)
`ifdef TIMEKEEPING_ALARM_EN
      ,
      .alarm_set    (alarm_set),
      .alarm_clear  (alarm_clear),
      .alarm_hours  (alarm_hours),
      .alarm_minutes(alarm_minutes),
      .alarm_ring   (alarm_ring)
`endif
   );

   function automatic vec_t exp_vec();
      int h, hd;
      h  = m_t / 3600;
      hd = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
      return {W'(hd), W'((m_t / 60) % 60), W'(m_t % 60), (mode_12h && h >= 12),
              m_sp, m_dw, m_le, a_ring};
   endfunction

   function automatic vec_t obs_vec();
      logic r;
`ifdef TIMEKEEPING_ALARM_EN
      r = alarm_ring;
`else
      r = 1'b0;
`endif
      return {hours_disp, min_disp, sec_disp, pm, sec_pulse, day_wrap, load_err, r};
   endfunction

   task automatic model_update();
      int  h, m, s;
      bit  tick, ok, hit;
      if (!reset_n) begin
         m_t = 0; m_ph = 0; m_sp = 0; m_dw = 0; m_le = 0;
         a_t = 0; a_arm = 0; a_ring = 0;
         return;
      end
      m_sp = 0; m_dw = 0; m_le = 0; hit = 0;
      tick = run && (m_ph == int'(HZ) - 1);
      ok   = load_hours < 24 && load_minutes < 60 && load_seconds < 60;
      if (load_time) begin
         if (ok) begin
            m_t  = load_hours * 3600 + load_minutes * 60 + load_seconds;
            m_ph = 0;
         end else begin
            m_le = 1;
         end
      end else begin
         if (run) m_ph = (m_ph + 1) % int'(HZ);
         if (inc_hour || inc_min) begin
            h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
            if (inc_hour) h = (h + 1) % 24;
            if (inc_min)  m = (m + 1) % 60;
            m_t = h * 3600 + m * 60 + s;
         end else if (tick) begin
            m_t  = (m_t + 1) % 86400;
            m_sp = 1;
            m_dw = (m_t == 0);
            hit  = (m_t == a_t);
         end
      end
`ifdef TIMEKEEPING_ALARM_EN
      if (alarm_set && !(alarm_hours < 24 && alarm_minutes < 60)) m_le = 1;
      if (alarm_clear) begin
         a_arm = 0; a_ring = 0;
      end else begin
         if (hit && a_arm) a_ring = 1;
         if (alarm_set && alarm_hours < 24 && alarm_minutes < 60) begin
            a_t = alarm_hours * 3600 + alarm_minutes * 60; a_arm = 1;
         end
      end
`else
      if (hit) a_t = a_t;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      load_time = 0; inc_hour = 0; inc_min = 0;
`ifdef TIMEKEEPING_ALARM_EN
      alarm_set = 0; alarm_clear = 0;
`endif
   endtask

   task automatic do_load(input int h, input int m, input int s);
      load_time = 1; load_hours = W'(h); load_minutes = W'(m); load_seconds = W'(s);
      step();
      idle();
   endtask

   task automatic test_reset();
      reset_n = 0; run = 1; mode_12h = 0; idle();
      load_time = 1; load_hours = 8'd10; load_minutes = 8'd10; load_seconds = 8'd10;
      repeat (3) step();
      idle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_model got %h want %h", obs_vec(), exp_vec());
      end
      checks++;
      if (obs_vec() !== '0) begin
         errors++; $display("FAIL reset_zero got %h want 0", obs_vec());
      end
   endtask

   task automatic test_prescaler();
      reset_n = 1; run = 1;
      for (int k = 1; k <= 12; k++) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL presc_model k=%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         checks++;
         if (sec_pulse !== (k % 4 == 0) || sec_disp !== W'(k / 4)) begin
            errors++;
            $display("FAIL presc_pulse k=%0d got sp=%b s=%0d want sp=%b s=%0d",
                     k, sec_pulse, sec_disp, (k % 4 == 0), k / 4);
         end
      end
   endtask

   task automatic test_wrap();
      int dw_cnt;
      dw_cnt = 0; run = 1;
      do_load(23, 59, 58);
      for (int k = 0; k < 12; k++) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL wrap_model k=%0d got %h want %h", k, obs_vec(), exp_vec());
         end
         if (day_wrap === 1'b1) begin
            dw_cnt++;
            checks++;
            if ({hours_disp, min_disp, sec_disp} !== '0) begin
               errors++;
               $display("FAIL wrap_zero got %0d:%0d:%0d want 0:0:0", hours_disp, min_disp, sec_disp);
            end
         end
      end
      checks++;
      if (dw_cnt != 1) begin
         errors++; $display("FAIL wrap_count got %0d want 1", dw_cnt);
      end
   endtask

   task automatic test_load();
      int bad_h[2] = '{24, 10};
      int bad_m[2] = '{0, 60};
      run = 0;
      do_load(12, 34, 56);
      for (int i = 0; i < 2; i++) begin
         do_load(bad_h[i], bad_m[i], 0);
         checks++;
         if (load_err !== 1'b1 || hours_disp !== 8'd12 || min_disp !== 8'd34 || sec_disp !== 8'd56) begin
            errors++;
            $display("FAIL load_bad%0d got err=%b %0d:%0d:%0d want err=1 12:34:56",
                     i, load_err, hours_disp, min_disp, sec_disp);
         end
         step();
         checks++;
         if (load_err !== 1'b0) begin
            errors++; $display("FAIL load_err_once got %b want 0", load_err);
         end
      end
      run = 1;
      for (int k = 0; k < int'(HZ) && m_ph != int'(HZ) - 1; k++) step();
      checks++;
      if (m_ph != int'(HZ) - 1) begin
         errors++; $display("FAIL load_phase got %0d want %0d", m_ph, HZ - 1);
      end
      do_load(10, 15, 30);
      checks++;
      if (hours_disp !== 8'd10 || min_disp !== 8'd15 || sec_disp !== 8'd30 || sec_pulse !== 1'b0) begin
         errors++;
         $display("FAIL load_tick got %0d:%0d:%0d sp=%b want 10:15:30 sp=0",
                  hours_disp, min_disp, sec_disp, sec_pulse);
      end
   endtask

   task automatic test_inc();
      run = 0;
      do_load(9, 59, 40);
      inc_min = 1; step(); idle();
      checks++;
      if (hours_disp !== 8'd9 || min_disp !== 8'd0 || sec_disp !== 8'd40) begin
         errors++; $display("FAIL inc_min got %0d:%0d:%0d want 9:0:40", hours_disp, min_disp, sec_disp);
      end
      do_load(23, 10, 5);
      inc_hour = 1; step(); idle();
      checks++;
      if (hours_disp !== 8'd0 || min_disp !== 8'd10 || sec_disp !== 8'd5 || day_wrap !== 1'b0) begin
         errors++;
         $display("FAIL inc_hour got %0d:%0d:%0d dw=%b want 0:10:5 dw=0",
                  hours_disp, min_disp, sec_disp, day_wrap);
      end
      do_load(23, 59, 59);
      run = 1; inc_hour = 1; inc_min = 1; step(); idle(); run = 0;
      checks++;
      if (obs_vec() !== exp_vec() || {hours_disp, min_disp, sec_disp} !== {8'd0, 8'd0, 8'd59}) begin
         errors++; $display("FAIL inc_both got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_mode12();
      int hrs[4]  = '{0, 12, 13, 23};
      int disp[4] = '{12, 12, 1, 11};
      bit pms[4]  = '{0, 1, 1, 1};
      run = 0; mode_12h = 1;
      for (int i = 0; i < 4; i++) begin
         do_load(hrs[i], 0, 0);
         checks++;
         if (hours_disp !== W'(disp[i]) || pm !== pms[i]) begin
            errors++;
            $display("FAIL mode12_h%0d got %0d pm=%b want %0d pm=%b", hrs[i], hours_disp, pm, disp[i], pms[i]);
         end
      end
      mode_12h = 0; #1;
      checks++;
      if (hours_disp !== 8'd23 || pm !== 1'b0) begin
         errors++; $display("FAIL mode24_switch got %0d pm=%b want 23 pm=0", hours_disp, pm);
      end
   endtask

   task automatic test_pause();
      run = 1;
      do_load(5, 6, 7);
      run = 0;
      repeat (10) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec() || {hours_disp, min_disp, sec_disp} !== {8'd5, 8'd6, 8'd7}) begin
            errors++; $display("FAIL pause got %h want %h", obs_vec(), exp_vec());
         end
      end
   endtask

`ifdef TIMEKEEPING_ALARM_EN
   task automatic test_alarm();
      run = 0;
      alarm_set = 1; alarm_hours = 8'd7; alarm_minutes = 8'd30; step(); idle();
      do_load(7, 30, 0);
      checks++;
      if (alarm_ring !== 1'b0) begin
         errors++; $display("FAIL alarm_load got %b want 0", alarm_ring);
      end
      do_load(7, 29, 59);
      run = 1;
      repeat (int'(HZ) + 1) step();
      checks++;
      if (alarm_ring !== 1'b1 || obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL alarm_ring got %b want 1", alarm_ring);
      end
      repeat (6) step();
      checks++;
      if (alarm_ring !== 1'b1) begin
         errors++; $display("FAIL alarm_hold got %b want 1", alarm_ring);
      end
      alarm_clear = 1; step(); idle();
      checks++;
      if (alarm_ring !== 1'b0) begin
         errors++; $display("FAIL alarm_clear got %b want 0", alarm_ring);
      end
      alarm_set = 1; alarm_hours = 8'd24; alarm_minutes = 8'd0; step(); idle();
      checks++;
      if (load_err !== 1'b1) begin
         errors++; $display("FAIL alarm_bad got %b want 1", load_err);
      end
      reset_n = 0; step(); reset_n = 1;
      checks++;
      if (obs_vec() !== '0) begin
         errors++; $display("FAIL alarm_reset got %h want 0", obs_vec());
      end
   endtask
`endif

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         reset_n      = ($urandom_range(0, 199) != 0);
         run          = ($urandom_range(0, 9) < 8);
         mode_12h     = $urandom_range(0, 1);
         load_time    = ($urandom_range(0, 29) == 0);
         load_hours   = W'($urandom_range(0, 27));
         load_minutes = W'($urandom_range(0, 63));
         load_seconds = W'($urandom_range(0, 63));
         inc_hour     = ($urandom_range(0, 29) == 0);
         inc_min      = ($urandom_range(0, 19) == 0);
`ifdef TIMEKEEPING_ALARM_EN
         alarm_set     = ($urandom_range(0, 49) == 0);
         alarm_clear   = ($urandom_range(0, 99) == 0);
         alarm_hours   = W'($urandom_range(0, 25));
         alarm_minutes = W'($urandom_range(0, 61));
`endif
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL random k=%0d got %h want %h", k, obs_vec(), exp_vec());
         end
      end
      reset_n = 1; idle();
   endtask

   initial begin
      test_reset();
      test_prescaler();
      test_wrap();
      test_load();
      test_inc();
      test_mode12();
      test_pause();
`ifdef TIMEKEEPING_ALARM_EN
      test_alarm();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
